scan_writeback: RTL and testbench

- Write-back end of the image scan path. The scan address counter reads the 150x150 input image in one of four orders: LR, UD, TTL or TTR.
- This block takes the 1-bit edge-detector results that come back in that same order. It regenerates each pixel's (row, col) independently of the read side and writes the results into a result RAM.
- Each write is a read-modify-write OR-merge, so the four directional passes accumulate into a single edge map.
- It also checks that the upstream line-end flags fall where the scan geometry says they should.

---
 rtl/scan_pkg.sv | 18 +
 rtl/scan_pos_gen.sv | 120 ++++++++++++
 rtl/scan_writeback.sv | 136 +++++++++++++
 tb/tb_scan_writeback.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared scan definitions. The read-side address counter imports this same
// package, so both ends of the scan path agree on the mode encodings.
package scan_pkg;

    typedef enum logic [1:0] {
        MODE_LR  = 2'd0,
        MODE_UD  = 2'd1,
        MODE_TTL = 2'd2,
        MODE_TTR = 2'd3
    } scan_mode_e;

    // Image side, RAM address width (2^AW >= N*N) and
    // row/col/diagonal width (2^RW > 2N, so diagonals up to 2N-2 fit).
    localparam int SCAN_N  = 150;
    localparam int SCAN_AW = 15;
    localparam int SCAN_RW = 9;

endpackage

// File: rtl/scan_pos_gen.sv
// Regenerates the (row, col) scan position and its RAM address for the
// selected order. The address is updated incrementally inside a line; the
// row*N multiply is only evaluated to find the first pixel of a new diagonal.
module scan_pos_gen
    import scan_pkg::*;
#(
    parameter int N  = SCAN_N,
    parameter int AW = SCAN_AW,
    parameter int RW = SCAN_RW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  scan_mode_e    mode,
    input  logic          advance,
    output logic [AW-1:0] addr,
    output logic          line_end,
    output logic          last
);

    localparam logic [RW-1:0] EDGE_IDX = RW'(N - 1);
    localparam logic [AW-1:0] STEP_ROW = AW'(N);
    localparam logic [AW-1:0] STEP_TTL = AW'(N - 1);
    localparam logic [AW-1:0] STEP_TTR = AW'(N + 1);

    scan_mode_e    mode_q;
    logic [RW-1:0] row;
    logic [RW-1:0] col;
    logic [RW-1:0] diag;
    logic [RW-1:0] diag_nxt;
    logic [RW-1:0] row_start;
    logic [RW-1:0] col_start;
    logic [RW-1:0] offset;
    logic [AW-1:0] line_addr;

    // First pixel of the next diagonal: row = min(d, N-1), col from the offset.
    always_comb begin
        diag_nxt  = diag + RW'(1);
        row_start = (diag_nxt > EDGE_IDX) ? EDGE_IDX : diag_nxt;
        offset    = diag_nxt - row_start;
        col_start = (mode_q == MODE_TTR) ? EDGE_IDX - offset : offset;
        line_addr = AW'(row_start) * STEP_ROW + AW'(col_start);
    end

    // Geometric end of the current line or diagonal.
    always_comb begin
        case (mode_q)
            MODE_LR:  line_end = (col == EDGE_IDX);
            MODE_UD:  line_end = (row == EDGE_IDX);
            MODE_TTL: line_end = (row == '0) || (col == EDGE_IDX);
            default:  line_end = (row == '0) || (col == '0);
        endcase
    end

    // Only TTR finishes in the bottom-left corner; the others end bottom-right.
    assign last = (row == EDGE_IDX) &&
                  (col == ((mode_q == MODE_TTR) ? RW'(0) : EDGE_IDX));

    // Position register: loaded on start, stepped once per accepted result.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_LR;
            row    <= '0;
            col    <= '0;
            diag   <= '0;
            addr   <= '0;
        end else if (load) begin
            mode_q <= mode;
            row    <= '0;
            diag   <= '0;
            if (mode == MODE_TTR) begin
                col  <= EDGE_IDX;
                addr <= AW'(N - 1);
            end else begin
                col  <= '0;
                addr <= '0;
            end
        end else if (advance) begin
            case (mode_q)
                MODE_LR: begin
                    addr <= addr + AW'(1);
                    if (col == EDGE_IDX) begin
                        col <= '0;
                        row <= row + RW'(1);
                    end else begin
                        col <= col + RW'(1);
                    end
                end
                MODE_UD: begin
                    if (row == EDGE_IDX) begin
                        row  <= '0;
                        col  <= col + RW'(1);
                        addr <= AW'(col) + AW'(1);
                    end else begin
                        row  <= row + RW'(1);
                        addr <= addr + STEP_ROW;
                    end
                end
                default: begin
                    if (line_end) begin
                        diag <= diag_nxt;
                        row  <= row_start;
                        col  <= col_start;
                        addr <= line_addr;
                    end else begin
                        row <= row - RW'(1);
                        if (mode_q == MODE_TTL) begin
                            col  <= col + RW'(1);
                            addr <= addr - STEP_TTL;
                        end else begin
                            col  <= col - RW'(1);
                            addr <= addr - STEP_TTR;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/scan_writeback.sv
// Write-back end of the scan path: accepts 1-bit edge results in scan order,
// read-modify-writes them into the result RAM and checks upstream line ends.
//
//   state   | meaning
//   --------+------------------------------------------------------
//   S_IDLE  | after reset, waiting for start
//   S_RUN   | accepting results, in_ready high
//   S_DRAIN | last pixel accepted, final write still in flight
//   S_DONE  | pass complete, done high, waiting for start
module scan_writeback
    import scan_pkg::*;
#(
    parameter int N  = SCAN_N,
    parameter int AW = SCAN_AW,
    parameter int RW = SCAN_RW
) (
    input  logic          clk,
    input  logic          resetIn,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic          merge,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_edge,
    input  logic          in_line_end,
    output logic [AW-1:0] rd_addr,
    output logic          rd_en,
    input  logic          rd_data,
    output logic [AW-1:0] wr_addr,
    output logic          wr_en,
    output logic          wr_data,
    output logic          done,
    output logic          line_err,
    output logic [AW-1:0] pix_count
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

    state_e        state;
    logic          merge_q;
    logic          edge_s0;
    logic          edge_s1;
    logic          xfer;
    logic          load;
    logic [AW-1:0] pos_addr;
    logic          pos_line_end;
    logic          pos_last;

    assign xfer = in_valid && in_ready;
    assign load = start && ((state == S_IDLE) || (state == S_DONE));

    scan_pos_gen #(
        .N  (N),
        .AW (AW),
        .RW (RW)
    ) u_pos (
        .clk      (clk),
        .rst      (resetIn),
        .load     (load),
        .mode     (scan_mode_e'(mode)),
        .advance  (xfer),
        .addr     (pos_addr),
        .line_end (pos_line_end),
        .last     (pos_last)
    );

    // Pass control, accept count and sticky line-end error.
    always_ff @(posedge clk) begin
        if (resetIn) begin
            state     <= S_IDLE;
            in_ready  <= 1'b0;
            done      <= 1'b0;
            line_err  <= 1'b0;
            pix_count <= '0;
            merge_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_RUN;
                        in_ready  <= 1'b1;
                        done      <= 1'b0;
                        line_err  <= 1'b0;
                        pix_count <= '0;
                        merge_q   <= merge;
                    end
                end
                S_RUN: begin
                    if (xfer) begin
                        pix_count <= pix_count + AW'(1);
                        if (in_line_end != pos_line_end) begin
                            line_err <= 1'b1;
                        end
                        if (pos_last) begin
                            in_ready <= 1'b0;
                            state    <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // The read of the last pixel has retired; its write is on the bus now.
                    if (!rd_en) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Two-stage RMW: stage 0 issues the read, stage 1 writes the merged bit.
    always_ff @(posedge clk) begin
        if (resetIn) begin
            rd_en   <= 1'b0;
            rd_addr <= '0;
            edge_s0 <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            edge_s1 <= 1'b0;
        end else begin
            rd_en <= xfer;
            if (xfer) begin
                rd_addr <= pos_addr;
                edge_s0 <= in_edge;
            end
            wr_en   <= rd_en;
            wr_addr <= rd_addr;
            edge_s1 <= edge_s0;
        end
    end

    // Read data arrives during the write cycle, so the merge is combinational.
    assign wr_data = edge_s1 | (merge_q & rd_data);

endmodule

// File: tb/tb_scan_writeback.sv
// Bench for scan_writeback: a 4x4 instance for the small-pattern checks and a
// 150x150 instance for full-size passes, each with its own result RAM model.
module tb_scan_writeback;
    import scan_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetIn, start, merge, in_valid, in_edge, in_line_end;
    logic [1:0] mode;
    int         sel;

    logic       ready4, rd_en4, wr_en4, wr_data4, done4, lerr4;
    logic       rd_data4 = 1'b0;
    logic [4:0] rd_addr4, wr_addr4, pix4;

    logic        ready150, rd_en150, wr_en150, wr_data150, done150, lerr150;
    logic        rd_data150 = 1'b0;
    logic [14:0] rd_addr150, wr_addr150, pix150;

    scan_writeback #(.N(4), .AW(5), .RW(4)) dut4 (
        .clk(clk), .resetIn(resetIn), .start(start && (sel == 0)), .mode(mode), .merge(merge),
        .in_valid(in_valid), .in_ready(ready4), .in_edge(in_edge), .in_line_end(in_line_end),
        .rd_addr(rd_addr4), .rd_en(rd_en4), .rd_data(rd_data4),
        .wr_addr(wr_addr4), .wr_en(wr_en4), .wr_data(wr_data4),
        .done(done4), .line_err(lerr4), .pix_count(pix4)
    );

    scan_writeback #(.N(150), .AW(15), .RW(9)) dut150 (
        .clk(clk), .resetIn(resetIn), .start(start && (sel == 1)), .mode(mode), .merge(merge),
        .in_valid(in_valid), .in_ready(ready150), .in_edge(in_edge), .in_line_end(in_line_end),
        .rd_addr(rd_addr150), .rd_en(rd_en150), .rd_data(rd_data150),
        .wr_addr(wr_addr150), .wr_en(wr_en150), .wr_data(wr_data150),
        .done(done150), .line_err(lerr150), .pix_count(pix150)
    );

    bit mem4   [0:15];
    bit mem150 [0:22499];
    bit exp_img[0:22499];
    bit snap   [0:15];

    always @(posedge clk) begin
        if (rd_en4)   rd_data4   <= mem4[int'(rd_addr4)];
        if (wr_en4)   mem4[int'(wr_addr4)] <= wr_data4;
        if (rd_en150) rd_data150 <= mem150[int'(rd_addr150)];
        if (wr_en150) mem150[int'(wr_addr150)] <= wr_data150;
    end

    logic o_ready, o_wr_en, o_wr_data, o_done, o_lerr;
    int   o_wr_addr, o_pix;
    always_comb begin
        if (sel == 0) begin
            o_ready = ready4; o_wr_en = wr_en4; o_wr_data = wr_data4; o_done = done4;
            o_lerr = lerr4; o_wr_addr = int'(wr_addr4); o_pix = int'(pix4);
        end else begin
            o_ready = ready150; o_wr_en = wr_en150; o_wr_data = wr_data150; o_done = done150;
            o_lerr = lerr150; o_wr_addr = int'(wr_addr150); o_pix = int'(pix150);
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;
    int cur_n = 4;
    int last_acc = 0;
    int edge_kind = 0;
    int edge_idx = -1;
    int seq_q[$];
    bit le_q[$];
    int sb_addr[$];
    bit sb_data[$];
    int wlog[$];
    int mon_a;
    bit mon_d;

    // Scoreboard: every write must match the oldest expected write.
    always @(negedge clk) begin
        if (o_wr_en) begin
            wlog.push_back(o_wr_addr);
            n_vec++;
            if (sb_addr.size() == 0) begin
                n_bad++;
                $display("FAIL sb_extra_write got addr=%0d expected no write", o_wr_addr);
            end else begin
                mon_a = sb_addr.pop_front();
                mon_d = sb_data.pop_front();
                if (o_wr_addr !== mon_a || o_wr_data !== mon_d) begin
                    n_bad++;
                    $display("FAIL sb_write got addr=%0d data=%0b expected addr=%0d data=%0b",
                             o_wr_addr, o_wr_data, mon_a, mon_d);
                end
            end
        end
    end

    function automatic bit edge_of(input int k);
        if (edge_kind == 1) return (k == edge_idx);
        if (edge_kind == 2) return ((k * 7 + 3) % 5) == 0;
        return 1'b0;
    endfunction

    function automatic bit mem_rd(input int a);
        return (sel == 0) ? mem4[a] : mem150[a];
    endfunction

    // Reference scan order built row/col-wise, independent of any incremental stepping.
    function automatic void build_seq(input int n, input int m);
        int r0, o, c;
        seq_q.delete();
        le_q.delete();
        if (m == 0) begin
            for (int r = 0; r < n; r++)
                for (int cc = 0; cc < n; cc++) begin
                    seq_q.push_back(r * n + cc);
                    le_q.push_back(cc == n - 1);
                end
        end else if (m == 1) begin
            for (int cc = 0; cc < n; cc++)
                for (int r = 0; r < n; r++) begin
                    seq_q.push_back(r * n + cc);
                    le_q.push_back(r == n - 1);
                end
        end else begin
            for (int d = 0; d <= 2 * n - 2; d++) begin
                r0 = (d < n - 1) ? d : n - 1;
                for (int r = r0; r >= 0; r--) begin
                    o = d - r;
                    if (o <= n - 1) begin
                        c = (m == 2) ? o : n - 1 - o;
                        seq_q.push_back(r * n + c);
                        le_q.push_back((r == 0) || (o == n - 1));
                    end
                end
            end
        end
    endfunction

    task automatic drive_pass(input logic [1:0] m, input logic mg, input bit rnd,
                              input int bad_le, input int stop_at, input int glitch_at);
        int k, budget, total, a;
        bit e, d;
        total = cur_n * cur_n;
        k = 0;
        budget = total * 4 + 100;
        wlog.delete();
        @(negedge clk);
        mode = m; merge = mg; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (k < total && k != stop_at && budget > 0) begin
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start = (k == glitch_at);
            mode = (k == glitch_at) ? ~m : m;
            e = edge_of(k);
            in_edge = e;
            in_line_end = le_q[k] ^ (k == bad_le);
            if (o_ready && in_valid) begin
                a = seq_q[k];
                d = e | (mg & exp_img[a]);
                exp_img[a] = d;
                sb_addr.push_back(a);
                sb_data.push_back(d);
                k++;
                last_acc = cyc + 1;
            end
            @(negedge clk);
            budget--;
        end
        in_valid = 1'b0; start = 1'b0; in_edge = 1'b0; in_line_end = 1'b0; mode = m;
        if (budget == 0) begin
            n_vec++; n_bad++;
            $display("FAIL pass_timeout accepted=%0d required=%0d", k, total);
        end
    endtask

    task automatic wait_done(output logic rdy0, output logic d1, output logic d2, output int pix);
        rdy0 = o_ready;
        @(negedge clk);
        d1 = o_done;
        @(negedge clk);
        d2 = o_done;
        pix = o_pix;
    endtask

    function automatic int image_errors(input int total);
        int cnt = 0;
        for (int a = 0; a < total; a++)
            if (mem_rd(a) !== exp_img[a]) cnt++;
        return cnt;
    endfunction

    task automatic test_reset();
        n_vec++;
        if ({ready4, rd_en4, wr_en4, done4, lerr4, wr_data4} !== 6'b0 || pix4 !== 5'd0 ||
            wr_addr4 !== 5'd0 || rd_addr4 !== 5'd0) begin
            n_bad++;
            $display("FAIL reset4 got rdy=%0b rd=%0b wr=%0b done=%0b err=%0b pix=%0d expected all 0",
                     ready4, rd_en4, wr_en4, done4, lerr4, pix4);
        end
        n_vec++;
        if ({ready150, rd_en150, wr_en150, done150, lerr150, wr_data150} !== 6'b0 ||
            pix150 !== 15'd0 || wr_addr150 !== 15'd0 || rd_addr150 !== 15'd0) begin
            n_bad++;
            $display("FAIL reset150 got rdy=%0b rd=%0b wr=%0b done=%0b err=%0b pix=%0d expected all 0",
                     ready150, rd_en150, wr_en150, done150, lerr150, pix150);
        end
    endtask

    task automatic test_lr4();
        logic r0, d1, d2; int pix, errs;
        edge_kind = 1; edge_idx = 5;
        build_seq(4, 0);
        drive_pass(2'd0, 1'b0, 1'b0, -1, -1, -1);
        wait_done(r0, d1, d2, pix);
        n_vec++; if (r0 !== 1'b0) begin n_bad++; $display("FAIL lr4_ready_drop got=%0b exp=0", r0); end
        n_vec++; if (d1 !== 1'b0) begin n_bad++; $display("FAIL lr4_done_early got=%0b exp=0", d1); end
        n_vec++; if (d2 !== 1'b1) begin n_bad++; $display("FAIL lr4_done got=%0b exp=1", d2); end
        n_vec++; if (pix !== 16) begin n_bad++; $display("FAIL lr4_pix got=%0d exp=16", pix); end
        for (int i = 0; i < 16; i++) begin
            n_vec++;
            if (wlog.size() <= i || wlog[i] !== i) begin
                n_bad++;
                $display("FAIL lr4_wr_addr idx=%0d got=%0d exp=%0d", i, (wlog.size() > i) ? wlog[i] : -1, i);
            end
        end
        errs = 0;
        for (int a = 0; a < 16; a++) if (mem4[a] !== (a == 5)) errs++;
        n_vec++; if (errs != 0) begin n_bad++; $display("FAIL lr4_image got %0d wrong bits exp 0", errs); end
        n_vec++; if (o_lerr !== 1'b0) begin n_bad++; $display("FAIL lr4_line_err got=%0b exp=0", o_lerr); end
    endtask

    task automatic test_ttl4();
        int exp_seq[16] = '{0, 4, 1, 8, 5, 2, 12, 9, 6, 3, 13, 10, 7, 14, 11, 15};
        logic r0, d1, d2; int pix;
        edge_kind = 0;
        build_seq(4, 2);
        for (int k = 0; k < 16; k++) le_q[k] = (seq_q[k] inside {0, 1, 2, 3, 7, 11, 15});
        drive_pass(2'd2, 1'b0, 1'b0, -1, -1, -1);
        wait_done(r0, d1, d2, pix);
        for (int i = 0; i < 16; i++) begin
            n_vec++;
            if (wlog.size() <= i || wlog[i] !== exp_seq[i]) begin
                n_bad++;
                $display("FAIL ttl4_wr_addr idx=%0d got=%0d exp=%0d", i, (wlog.size() > i) ? wlog[i] : -1, exp_seq[i]);
            end
        end
        n_vec++; if (o_lerr !== 1'b0) begin n_bad++; $display("FAIL ttl4_line_err got=%0b exp=0", o_lerr); end
        n_vec++; if (d2 !== 1'b1 || pix !== 16) begin n_bad++; $display("FAIL ttl4_done got done=%0b pix=%0d exp 1/16", d2, pix); end
    endtask

    // A start pulse with a different mode mid-pass must be ignored.
    task automatic test_ttr4();
        int exp_seq[16] = '{3, 7, 2, 11, 6, 1, 15, 10, 5, 0, 14, 9, 4, 13, 8, 12};
        logic r0, d1, d2; int pix;
        edge_kind = 0;
        build_seq(4, 3);
        drive_pass(2'd3, 1'b0, 1'b0, -1, -1, 5);
        wait_done(r0, d1, d2, pix);
        for (int i = 0; i < 16; i++) begin
            n_vec++;
            if (wlog.size() <= i || wlog[i] !== exp_seq[i]) begin
                n_bad++;
                $display("FAIL ttr4_wr_addr idx=%0d got=%0d exp=%0d", i, (wlog.size() > i) ? wlog[i] : -1, exp_seq[i]);
            end
        end
        n_vec++; if (o_lerr !== 1'b0) begin n_bad++; $display("FAIL ttr4_line_err got=%0b exp=0", o_lerr); end
        n_vec++; if (d2 !== 1'b1 || pix !== 16) begin n_bad++; $display("FAIL ttr4_done got done=%0b pix=%0d exp 1/16", d2, pix); end
    endtask

    task automatic test_random_valid4();
        logic r0, d1, d2; int pix, errs;
        edge_kind = 2;
        build_seq(4, 2);
        drive_pass(2'd2, 1'b0, 1'b0, -1, -1, -1);
        wait_done(r0, d1, d2, pix);
        for (int a = 0; a < 16; a++) snap[a] = mem4[a];
        edge_kind = 0;
        drive_pass(2'd2, 1'b0, 1'b0, -1, -1, -1);
        wait_done(r0, d1, d2, pix);
        edge_kind = 2;
        drive_pass(2'd2, 1'b0, 1'b1, -1, -1, -1);
        wait_done(r0, d1, d2, pix);
        errs = 0;
        for (int a = 0; a < 16; a++) if (mem4[a] !== snap[a]) errs++;
        n_vec++; if (errs != 0) begin n_bad++; $display("FAIL rand_valid_vs_steady got %0d diffs exp 0", errs); end
        errs = image_errors(16);
        n_vec++; if (errs != 0) begin n_bad++; $display("FAIL rand_valid_image got %0d wrong bits exp 0", errs); end
        n_vec++; if (d2 !== 1'b1 || pix !== 16) begin n_bad++; $display("FAIL rand_valid_done got done=%0b pix=%0d exp 1/16", d2, pix); end
    endtask

    task automatic test_ud150();
        logic r0, d1, d2; int pix;
        int chk_i[5] = '{0, 1, 2, 149, 150};
        int chk_v[5] = '{0, 150, 300, 22350, 1};
        edge_kind = 0;
        build_seq(150, 1);
        drive_pass(2'd1, 1'b0, 1'b0, -1, -1, -1);
        wait_done(r0, d1, d2, pix);
        for (int j = 0; j < 5; j++) begin
            n_vec++;
            if (wlog.size() <= chk_i[j] || wlog[chk_i[j]] !== chk_v[j]) begin
                n_bad++;
                $display("FAIL ud150_wr_addr idx=%0d got=%0d exp=%0d", chk_i[j],
                         (wlog.size() > chk_i[j]) ? wlog[chk_i[j]] : -1, chk_v[j]);
            end
        end
        n_vec++;
        if (wlog.size() != 22500 || wlog[wlog.size() - 1] !== 22499) begin
            n_bad++;
            $display("FAIL ud150_final got writes=%0d exp 22500 ending at 22499", wlog.size());
        end
        n_vec++; if (d2 !== 1'b1 || pix !== 22500) begin n_bad++; $display("FAIL ud150_done got done=%0b pix=%0d exp 1/22500", d2, pix); end
    endtask

    task automatic test_lr_merge150();
        logic r0, d1, d2; int pix, ones;
        edge_kind = 1; edge_idx = 22499;
        build_seq(150, 0);
        drive_pass(2'd0, 1'b1, 1'b0, 148, -1, -1);
        wait_done(r0, d1, d2, pix);
        ones = 0;
        for (int a = 0; a < 22500; a++) if (mem150[a]) ones++;
        n_vec++;
        if (mem150[22499] !== 1'b1 || ones != 1) begin
            n_bad++;
            $display("FAIL merge150_image got bit22499=%0b ones=%0d exp 1/1", mem150[22499], ones);
        end
        n_vec++; if (o_lerr !== 1'b1) begin n_bad++; $display("FAIL merge150_line_err got=%0b exp=1", o_lerr); end
        n_vec++; if (d2 !== 1'b1 || pix !== 22500) begin n_bad++; $display("FAIL merge150_done got done=%0b pix=%0d exp 1/22500", d2, pix); end
    endtask

    task automatic test_reset150();
        logic r0, d1, d2; int pix, errs;
        edge_kind = 0;
        build_seq(150, 0);
        drive_pass(2'd0, 1'b0, 1'b0, -1, 37, -1);
        n_vec++; if (o_lerr !== 1'b0) begin n_bad++; $display("FAIL start_clears_line_err got=%0b exp=0", o_lerr); end
        resetIn = 1'b1;
        @(negedge clk);
        resetIn = 1'b0;
        n_vec++; if (o_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_squash_wr got=%0b exp=0", o_wr_en); end
        n_vec++; if (dut150.state !== 2'd0) begin n_bad++; $display("FAIL reset_state got=%0d exp=0", dut150.state); end
        n_vec++; if (o_done !== 1'b0 || o_ready !== 1'b0) begin n_bad++; $display("FAIL reset_outputs got done=%0b rdy=%0b exp 0/0", o_done, o_ready); end
        sb_addr.delete();
        sb_data.delete();
        edge_kind = 2;
        drive_pass(2'd0, 1'b0, 1'b0, -1, -1, -1);
        wait_done(r0, d1, d2, pix);
        n_vec++; if (o_lerr !== 1'b0) begin n_bad++; $display("FAIL rerun_line_err got=%0b exp=0", o_lerr); end
        n_vec++; if (d2 !== 1'b1 || pix !== 22500) begin n_bad++; $display("FAIL rerun_done got done=%0b pix=%0d exp 1/22500", d2, pix); end
        errs = image_errors(22500);
        n_vec++; if (errs != 0) begin n_bad++; $display("FAIL rerun_image got %0d wrong bits exp 0", errs); end
        n_vec++; if (sb_addr.size() != 0) begin n_bad++; $display("FAIL rerun_missing_writes got %0d pending exp 0", sb_addr.size()); end
    endtask

    initial begin
        resetIn = 1'b1; start = 1'b0; mode = 2'd0; merge = 1'b0;
        in_valid = 1'b0; in_edge = 1'b0; in_line_end = 1'b0; sel = 0;
        repeat (3) @(negedge clk);
        test_reset();
        resetIn = 1'b0;
        sel = 0; cur_n = 4;
        test_lr4();
        test_ttl4();
        test_ttr4();
        test_random_valid4();
        sel = 1; cur_n = 150;
        for (int a = 0; a < 22500; a++) exp_img[a] = 1'b0;
        test_ud150();
        test_lr_merge150();
        test_reset150();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
